// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// Operand-fetch stage that sits directly in front of the ALU. It holds the
// general register file, reads the two source registers, runs the B operand
// through a one-bit shifter and applies the A/B source selects. The resulting
// operand set is captured in a single-entry output slot that has a
// valid/ready handshake, so the ALU can stall the fetch. ALU results are
// written back through the register-file write port.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (clears the register file and
//              discards any held operand set)
//   in_valid   upstream presents an operand request this cycle
//   in_ready   stage can accept a request this cycle
//   rn, rm     register indices for the A and B operands
//   shift      B-path shift: 00 none, 01 shl1, 10 lsr1, 11 asr1
//   asel       1: A forced to zero, 0: R[rn]
//   bsel       1: B = sximm5, 0: shifted R[rm]
//   sximm5     sign-extended immediate from the decoder
//   aluop_in   ALU operation carried alongside the operands
//   write      register-file write enable
//   writenum   register-file write index
//   data_in    register-file write data (ALU result C)
//   out_valid  Ain/Bin/ALUop hold a valid operand set
//   out_ready  ALU consumes the operand set this cycle
//   Ain, Bin   registered A and B operands
//   ALUop      registered ALU operation
// -----------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int W    = 16,
    parameter int NREG = 8
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [$clog2(NREG)-1:0] rn,
    input  logic [$clog2(NREG)-1:0] rm,
    input  logic [1:0]              shift,
    input  logic                    asel,
    input  logic                    bsel,
    input  logic [W-1:0]            sximm5,
    input  logic [1:0]              aluop_in,

    input  logic                    write,
    input  logic [$clog2(NREG)-1:0] writenum,
    input  logic [W-1:0]            data_in,

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            Ain,
    output logic [W-1:0]            Bin,
    output logic [1:0]              ALUop
);

    // Output-slot occupancy. The state is the valid bit itself.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [W-1:0] regs [NREG];

    logic [W-1:0] rd_a;      // R[rn] after write bypass
    logic [W-1:0] rd_b;      // R[rm] after write bypass
    logic [W-1:0] shifted_b;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;

    logic accept;
    logic consume;

    // -------------------------------------------------------------------------
    // Register file
    // -------------------------------------------------------------------------
    // NOTE: every register here is cleared by reset; the file is only eight
    // words of flops, and software relies on R0..R7 reading zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (write) begin
            // NOTE: non-blocking so every flop in this clock domain samples
            // pre-edge values regardless of process ordering.
            regs[writenum] <= data_in;
        end
    end

    // Writeback landing this cycle is forwarded so a request issued alongside
    // it sees the new value instead of the stale register contents. Each read
    // port checks the write index independently.
    always_comb begin
        rd_a = regs[rn];
        rd_b = regs[rm];
        if (write && (writenum == rn)) begin
            rd_a = data_in;
        end
        if (write && (writenum == rm)) begin
            rd_b = data_in;
        end
    end

    // -------------------------------------------------------------------------
    // B-path shifter and source selects
    // -------------------------------------------------------------------------
    // NOTE: the default assignment first guarantees every path through the
    // block drives the output, so no latch is inferred.
    always_comb begin
        shifted_b = rd_b;
        case (shift)
            2'b01:   shifted_b = {rd_b[W-2:0], 1'b0};
            2'b10:   shifted_b = {1'b0, rd_b[W-1:1]};
            2'b11:   shifted_b = {rd_b[W-1], rd_b[W-1:1]};
            default: shifted_b = rd_b;
        endcase
    end

    assign op_a = asel ? '0 : rd_a;
    assign op_b = bsel ? sximm5 : shifted_b;

    // -------------------------------------------------------------------------
    // Handshake and slot state machine
    // -------------------------------------------------------------------------
    // A full slot can still take a new set in the cycle the ALU drains it,
    // which keeps back-to-back transfers bubble-free.
    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (consume && !accept) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output operand registers
    // -------------------------------------------------------------------------
    // Loaded only on accept; after a consume they keep their last contents,
    // and later writes to the source registers never reach a held set.
    always_ff @(posedge clk) begin
        if (reset) begin
            Ain   <= '0;
            Bin   <= '0;
            ALUop <= 2'b00;
        end else if (accept) begin
            Ain   <= op_a;
            Bin   <= op_b;
            ALUop <= aluop_in;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
//
// Directed bench for alu_operand_stage: a table of single-cycle requests with
// hand-computed operands, followed by hand-written sequences for bypass,
// stall, back-to-back and reset-during-transfer behaviour.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [15:0] sximm5;
    logic [1:0]  aluop_in;
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Ain;
    logic [15:0] Bin;
    logic [1:0]  ALUop;

    int total = 0;
    int bad   = 0;

    alu_operand_stage #(.W(16), .NREG(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rn        (rn),
        .rm        (rm),
        .shift     (shift),
        .asel      (asel),
        .bsel      (bsel),
        .sximm5    (sximm5),
        .aluop_in  (aluop_in),
        .write     (write),
        .writenum  (writenum),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Ain       (Ain),
        .Bin       (Bin),
        .ALUop     (ALUop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  rn;
        logic [2:0]  rm;
        logic [1:0]  shift;
        logic        asel;
        logic        bsel;
        logic [15:0] imm;
        logic [1:0]  op;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [15:0] val);
        write    = 1'b1;
        writenum = idx;
        data_in  = val;
        step();
        write    = 1'b0;
    endtask

    task automatic req(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sh,
                       input logic as, input logic bs, input logic [15:0] imm,
                       input logic [1:0] op);
        in_valid = 1'b1;
        rn       = a;
        rm       = b;
        shift    = sh;
        asel     = as;
        bsel     = bs;
        sximm5   = imm;
        aluop_in = op;
    endtask

    initial begin
        // rn   rm   sh     as    bs    imm       op     exp_a     exp_b
        vecs[0] = '{3'd3, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0007, 16'h8002};
        vecs[1] = '{3'd3, 3'd5, 2'b01, 1'b0, 1'b0, 16'h0000, 2'b01, 16'h0007, 16'h0004};
        vecs[2] = '{3'd3, 3'd5, 2'b10, 1'b0, 1'b0, 16'h0000, 2'b10, 16'h0007, 16'h4001};
        vecs[3] = '{3'd3, 3'd5, 2'b11, 1'b0, 1'b0, 16'h0000, 2'b11, 16'h0007, 16'hC001};
        vecs[4] = '{3'd3, 3'd5, 2'b11, 1'b0, 1'b1, 16'hFFF0, 2'b00, 16'h0007, 16'hFFF0};
        vecs[5] = '{3'd5, 3'd5, 2'b01, 1'b0, 1'b1, 16'hFFF0, 2'b01, 16'h8002, 16'hFFF0};
        vecs[6] = '{3'd3, 3'd3, 2'b00, 1'b1, 1'b0, 16'h0000, 2'b10, 16'h0000, 16'h0007};
        vecs[7] = '{3'd5, 3'd3, 2'b10, 1'b0, 1'b0, 16'h0000, 2'b11, 16'h8002, 16'h0003};

        reset     = 1'b1;
        in_valid  = 1'b0;
        rn        = '0;
        rm        = '0;
        shift     = '0;
        asel      = 1'b0;
        bsel      = 1'b0;
        sximm5    = '0;
        aluop_in  = '0;
        write     = 1'b0;
        writenum  = '0;
        data_in   = '0;
        out_ready = 1'b1;

        // ---- reset state ----
        step();
        step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_Ain", {16'd0, Ain}, 32'd0);
        check("rst_Bin", {16'd0, Bin}, 32'd0);
        check("rst_ALUop", {30'd0, ALUop}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;

        wr(3'd3, 16'h0007);
        wr(3'd5, 16'h8002);

        // ---- table: consecutive requests, also exercises back-to-back flow ----
        for (int i = 0; i < 8; i++) begin
            req(vecs[i].rn, vecs[i].rm, vecs[i].shift, vecs[i].asel, vecs[i].bsel,
                vecs[i].imm, vecs[i].op);
            #1;
            check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            step();
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d_Ain", i), {16'd0, Ain}, {16'd0, vecs[i].exp_a});
            check($sformatf("vec%0d_Bin", i), {16'd0, Bin}, {16'd0, vecs[i].exp_b});
            check($sformatf("vec%0d_ALUop", i), {30'd0, ALUop}, {30'd0, vecs[i].op});
        end

        // Consume without a new request: slot empties, operands retained.
        in_valid = 1'b0;
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_Ain_hold", {16'd0, Ain}, 32'h8002);
        check("drain_Bin_hold", {16'd0, Bin}, 32'h0003);

        // ---- write-read bypass on both ports ----
        write    = 1'b1;
        writenum = 3'd2;
        data_in  = 16'h1234;
        req(3'd2, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b01);
        step();
        write = 1'b0;
        check("byp_Ain", {16'd0, Ain}, 32'h1234);
        check("byp_Bin", {16'd0, Bin}, 32'h1234);
        // Next cycle R2 holds the written value with no bypass active.
        req(3'd2, 3'd2, 2'b10, 1'b0, 1'b0, 16'h0000, 2'b00);
        step();
        check("byp_after_Ain", {16'd0, Ain}, 32'h1234);
        check("byp_after_Bin", {16'd0, Bin}, 32'h091A);

        // ---- stall ----
        req(3'd3, 3'd3, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b10);
        step();
        check("stall_load_Ain", {16'd0, Ain}, 32'h0007);
        out_ready = 1'b0;
        req(3'd5, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b11);
        write    = 1'b1;
        writenum = 3'd3;
        data_in  = 16'hAAAA;
        #1;
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        write = 1'b0;
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_Ain_hold", {16'd0, Ain}, 32'h0007);
        check("stall_Bin_hold", {16'd0, Bin}, 32'h0007);
        check("stall_ALUop_hold", {30'd0, ALUop}, 32'd2);
        step();
        check("stall2_Ain_hold", {16'd0, Ain}, 32'h0007);
        // Release: pending request is taken in the same cycle as the consume.
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("release_valid", {31'd0, out_valid}, 32'd1);
        check("release_Ain", {16'd0, Ain}, 32'h8002);
        check("release_ALUop", {30'd0, ALUop}, 32'd3);
        // The stalled write to R3 did land in the register file.
        req(3'd3, 3'd3, 2'b11, 1'b0, 1'b0, 16'h0000, 2'b00);
        step();
        check("stall_wr_R3_A", {16'd0, Ain}, 32'hAAAA);
        check("stall_wr_R3_B", {16'd0, Bin}, 32'hD555);

        // ---- back-to-back, three consecutive sets in order ----
        req(3'd5, 3'd3, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b01);
        step();
        check("b2b0_valid", {31'd0, out_valid}, 32'd1);
        check("b2b0_Ain", {16'd0, Ain}, 32'h8002);
        req(3'd2, 3'd5, 2'b01, 1'b0, 1'b0, 16'h0000, 2'b10);
        step();
        check("b2b1_valid", {31'd0, out_valid}, 32'd1);
        check("b2b1_Ain", {16'd0, Ain}, 32'h1234);
        check("b2b1_Bin", {16'd0, Bin}, 32'h0004);
        req(3'd3, 3'd2, 2'b00, 1'b1, 1'b1, 16'h000F, 2'b11);
        step();
        in_valid = 1'b0;
        check("b2b2_valid", {31'd0, out_valid}, 32'd1);
        check("b2b2_Ain", {16'd0, Ain}, 32'h0000);
        check("b2b2_Bin", {16'd0, Bin}, 32'h000F);
        check("b2b2_ALUop", {30'd0, ALUop}, 32'd3);

        // ---- reset while holding a set, with a concurrent write ----
        wr(3'd1, 16'h5555);
        out_ready = 1'b0;
        req(3'd1, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b10);
        step();
        in_valid = 1'b0;
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        check("pre_rst_Ain", {16'd0, Ain}, 32'h5555);
        reset    = 1'b1;
        write    = 1'b1;
        writenum = 3'd1;
        data_in  = 16'hFFFF;
        step();
        reset = 1'b0;
        write = 1'b0;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_Ain", {16'd0, Ain}, 32'd0);
        check("midrst_Bin", {16'd0, Bin}, 32'd0);
        check("midrst_ALUop", {30'd0, ALUop}, 32'd0);
        out_ready = 1'b1;
        req(3'd1, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b01);
        step();
        in_valid = 1'b0;
        check("midrst_R1", {16'd0, Ain}, 32'd0);
        check("midrst_R5", {16'd0, Bin}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
